// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared definitions for the seq_detect_param serial pattern detector:
//   the default configuration loaded at reset, the helper that sizes the
//   pattern-length field, and the mask helper used by the match compare.
//   No ports (package).
package seq_det_pkg;

    // Widest mask that len_mask can build. MAX_LEN of the detector must not exceed this.
    localparam int MASK_W = 64;

    // Configuration restored by reset.
    localparam logic [7:0] DEF_PATTERN_C = 8'b0000_0101;
    localparam int         DEF_LEN_C     = 3;
    localparam bit         DEF_OVERLAP_C = 1'b1;

    // Bits needed to hold a length of 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Mask with the low 'len' bits set. The caller truncates it to its own width.
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// sat_counter
//   Saturating up-counter. Holds at all-ones instead of wrapping.
//   A clear request wins over an increment in the same cycle.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous reset, active-high (count -> 0)
//   clr  in   synchronous clear (count -> 0), priority over inc
//   inc  in   increment request
//   q    out  current count, W bits
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Runtime-configurable serial pattern detector. Compares the newest 'len'
//   received bits against the active pattern and raises a registered
//   (Moore) detect flag one cycle after the edge that accepts the final
//   pattern bit. Supports overlapping and non-overlapping matching, an
//   input-valid qualifier and a saturating hit counter.
//
//   Handshake: there is no backpressure. A bit is accepted on every rising
//   edge where in_valid=1 and cfg_load=0; a bit offered alongside cfg_load is
//   dropped. cfg_load is a single-cycle request with no acknowledge other than
//   cfg_err, which is valid the cycle after the request.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   in_valid     in   qualifies in_bit
//   in_bit       in   serial data bit
//   cfg_load     in   load cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  in   new pattern, bit [len-1] is received first
//   cfg_len      in   new length, legal 1..MAX_LEN
//   cfg_overlap  in   1 = overlapping matches
//   cnt_clr      in   clear hit_count
//   detect       out  match flag (registered)
//   hit_count    out  saturating match count
//   cfg_err      out  sticky: last cfg_load was rejected
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                   MAX_LEN     = 8,
    parameter int                   CNT_W       = 16,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                   DEF_LEN     = DEF_LEN_C,
    parameter bit                   DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int                  LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               detect,
    output logic [CNT_W-1:0]   hit_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    // Active configuration
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    // Datapath state
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_q, det_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] nh;
    logic [LEN_W-1:0]   nf;
    logic [MAX_LEN-1:0] mask;
    logic               match;
    logic               cfg_legal;
    logic               load_ok;
    logic               accept;

    assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    assign load_ok   = cfg_load && cfg_legal;
    assign accept    = in_valid && !cfg_load;

    // Candidate history/fill if the current bit is accepted.
    assign nh   = {hist_q[MAX_LEN-2:0], in_bit};
    assign nf   = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
    assign mask = MAX_LEN'(len_mask(int'(len_q)));

    // fill guards against matching on history bits that were never received
    // (after reset, a load, or a non-overlapping hit).
    assign match = (nf >= len_q) && (((nh ^ pat_q) & mask) == '0);

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = det_q;
        err_d  = err_q;
        if (cfg_load) begin
            if (cfg_legal) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
                det_d  = 1'b0;
                err_d  = 1'b0;
            end else begin
                // Rejected load leaves configuration and datapath untouched.
                err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = nh;
            det_d  = match;
            // Non-overlapping: forget consumed bits so they cannot start the next match.
            fill_d = (match && !ovl_q) ? '0 : nf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
            err_q  <= err_d;
        end
    end

    // A legal load restarts the count; cnt_clr wins over a same-cycle match.
    sat_counter #(
        .W(CNT_W)
    ) u_hit_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr || load_ok),
        .inc(accept && match),
        .q  (hit_count)
    );

    assign detect  = det_q;
    assign cfg_err = err_q;

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-configurable serial pattern detector. It generalises the fixed "101" Moore detector to any pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping matching, an input-valid qualifier, and a saturating hit counter. It sits on a serial bit stream, such as a line decoder or frame-sync hunter, and gives a Moore-style `detect` flag plus a hit count to the control logic.

## Interface
- `MAX_LEN`, default 8: longest supported pattern in bits; must be at least 2.
- `CNT_W`, default 16: width of the hit counter.
- `DEF_PATTERN`, default 8'b0000_0101: pattern value after reset, right-aligned.
- `DEF_LEN`, default 3: pattern length after reset.
- `DEF_OVERLAP`, default 1: overlap mode after reset.
- `LEN_W` is derived as $clog2(MAX_LEN+1). It is a localparam, not overridable.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  `in_bit` is sampled only when this is 1.
- `in_bit`  in  1  serial data bit.
- `cfg_load`  in  1  single-cycle request to load a new configuration.
- `cfg_pattern`  in  MAX_LEN  new pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- `cfg_len`  in  LEN_W  new pattern length; legal values are 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `cnt_clr`  in  1  synchronous clear of `hit_count`.
- `detect`  out  1  Moore match flag.
- `hit_count`  out  CNT_W  number of matches, saturating.
- `cfg_err`  out  1  sticky flag: the last load was rejected.

## Operation
- **State:**
  - `hist`: MAX_LEN-bit shift register; the newest bit is bit 0.
  - `fill`: LEN_W-bit count of valid history bits, saturating at MAX_LEN.
  - `detect` register.
  - Active configuration: `pat`, `len`, `ovl`.
- **Accepted bit** (`in_valid`=1, `cfg_load`=0):
  - `nh` = {`hist`[MAX_LEN-2:0], `in_bit`}.
  - `nf` = min(`fill`+1, MAX_LEN).
  - `match` = (`nf` ≥ `len`) and (the low `len` bits of `nh` equal the low `len` bits of `pat`).
- **On an accepted bit:**
  - `hist` ← `nh`; `detect` ← `match`.
  - `fill` ← 0 if `match` and `ovl`=0; otherwise `fill` ← `nf`.
  - `hit_count` increments on `match` and saturates at 2^CNT_W−1.
- **Moore behaviour:** `detect` is a pure state bit. It holds its value through cycles with `in_valid`=0 and changes only on an accepted bit, `cfg_load`, or `rst`.
- **`cfg_load` with legal `cfg_len`:**
  - Load `pat`, `len`, `ovl`.
  - Clear `hist`, `fill`, `detect`, `hit_count`, and `cfg_err`.
- **`cfg_load` with `cfg_len`=0 or `cfg_len` > MAX_LEN:**
  - The configuration and all datapath state are unchanged.
  - `cfg_err` ← 1.
- **Priority:** `rst` > `cfg_load` > accepted bit.
  - A bit presented in the same cycle as `cfg_load` is discarded.
  - `cnt_clr` together with a match leaves `hit_count`=0. Clear wins.
  - `cnt_clr` does not affect `detect`.
- **Reset:**
  - `pat`=DEF_PATTERN, `len`=DEF_LEN, `ovl`=DEF_OVERLAP.
  - `hist`=0, `fill`=0, `detect`=0, `hit_count`=0, `cfg_err`=0.
  - Reset in the middle of a partial match discards the partial match.

## Timing
- `detect` rises in the cycle after the rising edge that accepts the final pattern bit. This is one cycle of latency; there is no combinational path from `in_bit` to `detect`.
- `hit_count` updates on the same edge as `detect`.
- A new configuration applies to the first bit accepted in the cycle after `cfg_load`.
- `cfg_err` is valid in the cycle after `cfg_load`.
- There is no backpressure, so the block accepts one bit every cycle when required.

## Structure
- Package `seq_det_pkg` holds:
  - a `clog2`-based `LEN_W` helper;
  - a `len_mask(len)` function that returns a MAX_LEN-bit mask of the low `len` ones;
  - the default-configuration constants.
- One sub-module, `sat_counter` (parameter W; ports `clk`, `rst`, `clr`, `inc`, `q`), which saturates and gives `clr` priority over `inc`.
- Everything else (history register, match compare, config registers) lives in the top module.

## Test plan
- **Reset default:** stream 1,0,1,0,1 with `in_valid`=1 every cycle.
  - `detect`=1 in the cycles after the 3rd and 5th bits.
  - `hit_count`=2.
- **Non-overlap:** load pattern 3'b101, `len`=3, `ovl`=0, then stream 1,0,1,0,1.
  - One hit only; `detect` is high only after the 3rd bit.
  - Stream 1,0,1 more: `hit_count`=2.
- **Gaps:** load pattern 8'hA5, `len`=8, with `in_valid` toggling randomly.
  - `detect` is asserted exactly once.
  - `detect` stays high across the invalid cycles until the next accepted bit.
- **Illegal config:** issue `cfg_load` with `cfg_len`=0, then with `cfg_len`=MAX_LEN+1.
  - `cfg_err`=1 both times; the previous pattern keeps matching.
  - A following legal load clears `cfg_err`.
- **Simultaneous events:**
  - `cfg_load` with `in_valid`=1: the bit is discarded and `fill`=0.
  - `cnt_clr` on a match cycle: `hit_count`=0 while `detect`=1.
- **Saturation and reset:**
  - With CNT_W=2 and `len`=1, stream five matching bits: `hit_count` holds at 3.
  - Assert `rst` mid-pattern: all outputs are 0 on the next cycle.
